// File: rtl/demux_stream.sv
//============================================================================
// Module      : demux_stream
// Description : 1-to-NUM_OUT packet stream demultiplexer with one register
//               stage per output; route is locked for the length of a packet.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module demux_stream #(
   parameter int WIDTH   = 8,
   parameter int NUM_OUT = 4,
   parameter int SEL_W   = $clog2(NUM_OUT)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [SEL_W-1:0]         sel,
   input  logic [WIDTH-1:0]         inp_data,
   input  logic                     inp_valid,
   input  logic                     inp_last,
   output logic                     inp_ready,
   output logic [NUM_OUT*WIDTH-1:0] out_data,
   output logic [NUM_OUT-1:0]       out_valid,
   output logic [NUM_OUT-1:0]       out_last,
   input  logic [NUM_OUT-1:0]       out_ready,
   output logic                     drop_err
);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_BUSY = 1'b1;

   logic [0:0]       state;
   logic [SEL_W-1:0] route;
   logic [SEL_W-1:0] dest;
   logic             in_range;
   logic             accept;
   logic [NUM_OUT-1:0] dest_hit;
   logic [NUM_OUT-1:0] slot_free;

   logic [WIDTH-1:0] slot_data  [NUM_OUT];
   logic             slot_valid [NUM_OUT];
   logic             slot_last  [NUM_OUT];

   // While a packet is open the latched route wins; otherwise live sel.
   assign dest     = (state == ST_BUSY) ? route : sel;
   assign in_range = (32'(dest) < NUM_OUT);

   // Out-of-range beats are always taken so the packet is swallowed.
   assign inp_ready = ~rst & (in_range ? |(dest_hit & slot_free) : 1'b1);
   assign accept    = inp_valid & inp_ready;

   generate
      for (genvar k = 0; k < NUM_OUT; k++) begin : g_slot
         assign dest_hit[k]  = (32'(dest) == k);
         assign slot_free[k] = ~slot_valid[k] | out_ready[k];

         // A load in the same cycle as a drain keeps valid asserted.
         always_ff @(posedge clk) begin
            if (rst) begin
               slot_valid[k] <= 1'b0;
               slot_last[k]  <= 1'b0;
               slot_data[k]  <= '0;
            end else if (accept && dest_hit[k]) begin
               slot_valid[k] <= 1'b1;
               slot_last[k]  <= inp_last;
               slot_data[k]  <= inp_data;
            end else if (slot_valid[k] && out_ready[k]) begin
               slot_valid[k] <= 1'b0;
            end
         end

         assign out_data[k*WIDTH +: WIDTH] = slot_data[k];
         assign out_valid[k]               = slot_valid[k];
         assign out_last[k]                = slot_last[k];
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         drop_err <= 1'b0;
      end else begin
         drop_err <= accept & ~in_range;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
         route <= '0;
      end else if (accept) begin
         case (state)
            ST_IDLE: begin
               if (!inp_last) begin
                  state <= ST_BUSY;
                  route <= sel;
               end
            end
            ST_BUSY: begin
               if (inp_last) begin
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_demux_stream.sv
//============================================================================
// Module      : tb_demux_stream
// Description : Scoreboard bench for demux_stream (NUM_OUT=4 and NUM_OUT=3).
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_demux_stream;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic [1:0] sel;
   logic [7:0] inp_data;
   logic       inp_last;

   logic        v4, r4, de4;
   logic [31:0] od4;
   logic [3:0]  ov4, ol4, ord4;

   logic        v3, r3, de3;
   logic [23:0] od3;
   logic [2:0]  ov3, ol3;
   logic [2:0]  ord3 = 3'b111;

   demux_stream #(.WIDTH(8), .NUM_OUT(4)) dut (
      .clk(clk), .rst(rst), .sel(sel), .inp_data(inp_data),
      .inp_valid(v4), .inp_last(inp_last), .inp_ready(r4),
      .out_data(od4), .out_valid(ov4), .out_last(ol4),
      .out_ready(ord4), .drop_err(de4)
   );

   demux_stream #(.WIDTH(8), .NUM_OUT(3)) dut3 (
      .clk(clk), .rst(rst), .sel(sel), .inp_data(inp_data),
      .inp_valid(v3), .inp_last(inp_last), .inp_ready(r3),
      .out_data(od3), .out_valid(ov3), .out_last(ol3),
      .out_ready(ord3), .drop_err(de3)
   );

   int n_checks = 0;
   int n_errors = 0;

   // Expected {last, data} per output of the NUM_OUT=4 instance.
   logic [8:0] q0[$], q1[$], q2[$], q3[$];
   bit         m_busy  [2];
   int         m_route [2];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic qpush(input int k, input logic [8:0] v);
      case (k)
         0: q0.push_back(v);
         1: q1.push_back(v);
         2: q2.push_back(v);
         default: q3.push_back(v);
      endcase
   endtask

   task automatic qpop(input int k, output bit has, output logic [8:0] v);
      has = 1'b0;
      v   = '0;
      case (k)
         0: if (q0.size() > 0) begin has = 1'b1; v = q0.pop_front(); end
         1: if (q1.size() > 0) begin has = 1'b1; v = q1.pop_front(); end
         2: if (q2.size() > 0) begin has = 1'b1; v = q2.pop_front(); end
         default: if (q3.size() > 0) begin has = 1'b1; v = q3.pop_front(); end
      endcase
   endtask

   // Every handshake on an output must match the oldest expected beat.
   always @(negedge clk) begin
      if (!rst) begin
         for (int k = 0; k < 4; k++) begin
            if (ov4[k] && ord4[k]) begin
               logic [8:0] got;
               logic [8:0] e;
               bit         has;
               got = {ol4[k], od4[k*8 +: 8]};
               qpop(k, has, e);
               check($sformatf("beat_expected_out%0d", k), {31'd0, has}, 32'd1);
               if (has) check($sformatf("beat_out%0d", k), {23'd0, got}, {23'd0, e});
            end
         end
         check("drop_err_n4", {31'd0, de4}, 32'd0);
         check("out_valid_n3", {29'd0, ov3}, 32'd0);
      end
   end

   task automatic drive(input logic [7:0] d, input logic l, input logic [1:0] s, input bit w);
      inp_data = d;
      inp_last = l;
      sel      = s;
      if (w) v3 = 1'b1;
      else   v4 = 1'b1;
   endtask

   task automatic wait_ready(input bit w, output int waits);
      waits = 0;
      @(negedge clk);
      while (((w ? r3 : r4) !== 1'b1) && waits < 50) begin
         waits++;
         @(negedge clk);
      end
      check("inp_ready_wait", {31'd0, (w ? r3 : r4)}, 32'd1);
   endtask

   // Beat is accepted at this edge; update the reference model.
   task automatic commit(input bit w);
      int dest;
      int num;
      @(posedge clk);
      num  = w ? 3 : 4;
      dest = m_busy[w] ? m_route[w] : int'(sel);
      if (dest < num && !w) qpush(dest, {inp_last, inp_data});
      if (!m_busy[w] && !inp_last) begin
         m_busy[w]  = 1'b1;
         m_route[w] = int'(sel);
      end else if (m_busy[w] && inp_last) begin
         m_busy[w] = 1'b0;
      end
      #1;
      v4 = 1'b0;
      v3 = 1'b0;
   endtask

   task automatic send(input logic [7:0] d, input logic l, input logic [1:0] s, input bit w);
      int waits;
      drive(d, l, s, w);
      wait_ready(w, waits);
      commit(w);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int waits;
      rst = 1'b1; sel = '0; inp_data = '0; inp_last = 1'b0;
      v4 = 1'b0; v3 = 1'b0; ord4 = 4'hF;
      m_busy[0] = 1'b0; m_busy[1] = 1'b0; m_route[0] = 0; m_route[1] = 0;

      // Reset
      @(posedge clk);
      @(negedge clk);
      check("ready_in_reset", {31'd0, r4}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("rst_out_valid", {28'd0, ov4}, 32'd0);
      check("rst_out_last", {28'd0, ol4}, 32'd0);
      check("rst_out_data", od4, 32'd0);
      check("rst_drop_err", {31'd0, de4}, 32'd0);
      check("ready_after_reset", {31'd0, r4}, 32'd1);
      @(posedge clk); #1;

      // 1: single-beat routing, then IDLE follows live sel
      send(8'hA5, 1'b1, 2'd2, 1'b0);
      @(negedge clk);
      check("t1_valid", {28'd0, ov4}, 32'h4);
      check("t1_data", {24'd0, od4[23:16]}, 32'hA5);
      check("t1_last", {31'd0, ol4[2]}, 32'd1);
      @(posedge clk); #1;
      send(8'h5A, 1'b1, 2'd0, 1'b0);
      @(negedge clk);
      check("t1_idle_route", {28'd0, ov4}, 32'h1);
      @(posedge clk); #1;

      // 2: sel change mid-packet is ignored
      send(8'h11, 1'b0, 2'd1, 1'b0);
      send(8'h22, 1'b0, 2'd3, 1'b0);
      send(8'h33, 1'b1, 2'd3, 1'b0);
      send(8'h44, 1'b1, 2'd3, 1'b0);
      @(negedge clk);
      check("t2_after_packet", {28'd0, ov4}, 32'h8);
      @(posedge clk); #1;

      // 3: back-pressure on out0 only stalls when out0 is dest
      ord4 = 4'b1110;
      send(8'hC0, 1'b1, 2'd0, 1'b0);
      sel = 2'd0;
      @(negedge clk);
      check("t3_stall_dest0", {31'd0, r4}, 32'd0);
      sel = 2'd1;
      #1;
      check("t3_free_dest1", {31'd0, r4}, 32'd1);
      @(posedge clk); #1;
      send(8'hD1, 1'b0, 2'd1, 1'b0);
      @(negedge clk);
      check("t3_out1_latency", {31'd0, ov4[1]}, 32'd1);
      check("t3_out1_data", {24'd0, od4[15:8]}, 32'hD1);
      @(posedge clk); #1;
      send(8'hD2, 1'b1, 2'd0, 1'b0);
      @(negedge clk);
      check("t3_out0_held_valid", {31'd0, ov4[0]}, 32'd1);
      check("t3_out0_held_data", {24'd0, od4[7:0]}, 32'hC0);
      ord4 = 4'hF;
      repeat (3) @(negedge clk);
      @(posedge clk); #1;

      // 4: full throughput, 16 beats to out2
      for (int i = 0; i < 16; i++) begin
         drive(8'(i), (i == 15), 2'd2, 1'b0);
         wait_ready(1'b0, waits);
         check("t4_no_stall", waits, 32'd0);
         if (i > 0) check("t4_valid_run", {31'd0, ov4[2]}, 32'd1);
         commit(1'b0);
      end
      @(negedge clk);
      check("t4_last_valid", {31'd0, ov4[2]}, 32'd1);
      check("t4_last_data", {24'd0, od4[23:16]}, 32'h0F);
      @(negedge clk);
      check("t4_drained", {31'd0, ov4[2]}, 32'd0);
      @(posedge clk); #1;

      // 5: out-of-range drop on the NUM_OUT=3 instance
      drive(8'hE1, 1'b0, 2'd3, 1'b1);
      wait_ready(1'b1, waits);
      check("t5_ready_beat1", waits, 32'd0);
      commit(1'b1);
      drive(8'hE2, 1'b1, 2'd0, 1'b1);
      wait_ready(1'b1, waits);
      check("t5_drop_pulse1", {31'd0, de3}, 32'd1);
      check("t5_ready_beat2", waits, 32'd0);
      commit(1'b1);
      @(negedge clk);
      check("t5_drop_pulse2", {31'd0, de3}, 32'd1);
      @(negedge clk);
      check("t5_drop_clear", {31'd0, de3}, 32'd0);
      @(posedge clk); #1;

      // 6: reset mid-packet
      send(8'h61, 1'b0, 2'd1, 1'b0);
      send(8'h62, 1'b0, 2'd1, 1'b0);
      ord4 = 4'b1101;
      rst  = 1'b1;
      q1.delete();
      m_busy[0] = 1'b0;
      @(posedge clk); #1;
      rst  = 1'b0;
      ord4 = 4'hF;
      @(negedge clk);
      check("t6_flushed", {28'd0, ov4}, 32'h0);
      @(posedge clk); #1;
      send(8'h70, 1'b1, 2'd0, 1'b0);
      @(negedge clk);
      check("t6_new_packet", {28'd0, ov4}, 32'h1);

      repeat (3) @(negedge clk);
      check("end_q0_empty", q0.size(), 32'd0);
      check("end_q1_empty", q1.size(), 32'd0);
      check("end_q2_empty", q2.size(), 32'd0);
      check("end_q3_empty", q3.size(), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/demux_stream.md
Name: demux_stream

Overview:
- Parameterized 1-to-NUM_OUT stream demultiplexer: the sequential counterpart to the team's selector muxes.
- Routes a packetized valid/ready input stream to one of NUM_OUT output streams.
- `sel` is sampled on the first beat of each packet and held until the beat carrying `inp_last` is accepted.
- Each output has a one-entry register stage, so downstream consumers drain independently at full throughput.

Parameters:
- WIDTH, 8, data width of each beat.
- NUM_OUT, 4, number of output streams; legal range 2..16; need not be a power of 2.
- SEL_W, $clog2(NUM_OUT), width of `sel`; derived, must not be overridden.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- sel  input  SEL_W  destination index, sampled only on the first beat of a packet.
- inp_data  input  WIDTH  input beat data.
- inp_valid  input  1  input beat valid.
- inp_last  input  1  marks the final beat of a packet.
- inp_ready  output  1  input beat accepted when inp_valid && inp_ready.
- out_data  output  NUM_OUT*WIDTH  concatenated output data; slice k is [k*WIDTH +: WIDTH].
- out_valid  output  NUM_OUT  per-output valid.
- out_last  output  NUM_OUT  per-output last.
- out_ready  input  NUM_OUT  per-output ready.
- drop_err  output  1  one-cycle pulse on each accepted beat routed to an out-of-range index.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - out_valid=0, out_last=0, out_data=0, drop_err=0.
  - FSM=IDLE, route register=0.
  - inp_ready reads 0 while rst is high.
- FSM states:
  - IDLE: no packet open. The effective destination `dest` is the live `sel`.
  - BUSY: packet open. `dest` is the latched route register; `sel` is ignored.
- FSM transitions:
  - IDLE -> BUSY on an accepted beat with inp_last=0; route register <= sel.
  - IDLE stays IDLE on an accepted beat with inp_last=1 (single-beat packet, routed by live sel).
  - BUSY -> IDLE on an accepted beat with inp_last=1.
  - No other transitions.
- Output slot k is "free" when out_valid[k]=0 or out_ready[k]=1.
- inp_ready:
  - In range (dest < NUM_OUT): inp_ready = slot[dest] free. Combinational from out_valid[dest], out_ready[dest] and sel/route; no dependence on inp_valid.
  - Out of range (dest >= NUM_OUT, only possible when NUM_OUT is not a power of 2): inp_ready=1.
- Acceptance, in range: slot[dest] loads data and last, and sets out_valid on the next edge.
  - Latency: exactly 1 cycle from acceptance to out_valid.
- Acceptance, out of range:
  - The beat is discarded and drop_err=1 for the following cycle (registered).
  - FSM tracks inp_last normally, so the whole packet is discarded.
- Output drain: out_valid[k] clears on out_valid[k] && out_ready[k] unless the slot is reloaded in the same cycle.
- Simultaneous load and drain on the same slot: the new beat replaces the old one and out_valid stays 1. Sustained 1 beat/cycle with out_ready held high.
- Non-destination slots drain independently while the input feeds another slot.
- Back-pressure on an output stalls the input only while that output is `dest`.
- out_data and out_last hold their value while out_valid=0 (not cleared on drain).
- Packet integrity:
  - Beats of one packet always go to one output, in order.
  - A `sel` change mid-packet has no effect.
  - A `sel` change while IDLE takes effect immediately, including on the same cycle as the first beat.
- Reset mid-packet: buffered beats are lost, FSM returns to IDLE, and the next accepted beat is treated as a packet start.
- Width rules: SEL_W = $clog2(NUM_OUT). Out-of-range detection compares against NUM_OUT as an unsigned value.

Test Plan:
1. Single-beat routing:
   - Stimulus: NUM_OUT=4, WIDTH=8, all out_ready=1; send inp_data=0xA5, inp_last=1, sel=2.
   - Required: next cycle out_valid=4'b0100, out_data slice 2=0xA5, out_last[2]=1; FSM stays IDLE.
2. Multi-beat packet ignores sel change:
   - Stimulus: sel=1, beats 0x11,0x22,0x33 (last on 0x33); change sel to 3 after the first beat.
   - Required: all three beats appear on out1 in order; out3 never valid; FSM returns to IDLE after 0x33.
3. Back-pressure isolation:
   - Stimulus: out_ready[0]=0; packet to out0 fills the slot; next packet to out1.
   - Required: inp_ready=0 while dest=0 and slot 0 is full. Once the out0 packet completes (or on release of out_ready[0]), a packet to out1 flows with out1 data valid 1 cycle after acceptance, while out0 holds its beat unchanged.
4. Full throughput:
   - Stimulus: 16 consecutive valid beats 0x00..0x0F to out2 with out_ready[2]=1.
   - Required: inp_ready=1 every cycle; out_valid[2] high for 16 consecutive cycles; data sequence intact.
5. Out-of-range drop:
   - Stimulus: NUM_OUT=3, sel=3, 2-beat packet.
   - Required: inp_ready=1; no out_valid asserted; drop_err pulses 2 cycles, each 1 cycle after acceptance.
6. Reset mid-packet:
   - Stimulus: assert rst for 1 cycle after the 2nd beat of a 4-beat packet to out1.
   - Required: out_valid=0 next cycle. The next beat with sel=0 routes to out0 as a new packet.
